// File: rtl/tx_interp_fifo.sv
// Symbol-rate I/Q buffer that replays each sample INTERP times into the DUC.
// Optional build macro: LINEAR_INTERP_EN (linear ramp instead of sample hold).
module tx_interp_fifo #(
    parameter int DW         = 6,
    parameter int INTERP     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DW-1:0]          I_IN,
    input  logic signed [DW-1:0]          Q_IN,
    output logic                          out_valid,
    output logic signed [DW-1:0]          I_OUT,
    output logic signed [DW-1:0]          Q_OUT,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int LG = $clog2(INTERP);
    localparam logic [LG-1:0] LAST = LG'(INTERP - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_n;

    logic [2*DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            full;
    logic            has_data;

    logic [LG-1:0]   phase;
    logic [LG-1:0]   phase_n;

    logic signed [DW-1:0] head_i;
    logic signed [DW-1:0] head_q;
    logic signed [DW-1:0] cur_i;
    logic signed [DW-1:0] cur_q;
    logic signed [DW-1:0] cur_i_n;
    logic signed [DW-1:0] cur_q_n;
    logic signed [DW-1:0] i_n;
    logic signed [DW-1:0] q_n;
    logic                 vld_n;
    logic                 uf_n;

`ifdef LINEAR_INTERP_EN
    localparam int PW = DW + LG + 3;

    logic signed [DW-1:0] prev_i;
    logic signed [DW-1:0] prev_q;
    logic signed [DW-1:0] prev_i_n;
    logic signed [DW-1:0] prev_q_n;

    // Ramp point k of INTERP between p and c; floor shift keeps it inside [p,c].
    function automatic logic signed [DW-1:0] lerp(
        input logic signed [DW-1:0] p,
        input logic signed [DW-1:0] c,
        input logic [LG-1:0]        k
    );
        logic signed [PW-1:0] d;
        logic signed [PW-1:0] m;
        logic signed [PW-1:0] s;
        d = PW'(c) - PW'(p);
        m = d * $signed(PW'({1'b0, k}) + PW'(1));
        s = m >>> LG;
        return DW'(PW'(p) + s);
    endfunction
`endif

    assign full     = (fifo_level == LW'(FIFO_DEPTH));
    assign has_data = (fifo_level != '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign {head_i, head_q} = mem[rd_ptr];

    // Sample storage; contents need no reset since the pointers guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {I_IN, Q_IN};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, pop request and next output values.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        phase_n = phase;
        cur_i_n = cur_i;
        cur_q_n = cur_q;
        vld_n   = out_valid;
        uf_n    = 1'b0;
`ifdef LINEAR_INTERP_EN
        prev_i_n = prev_i;
        prev_q_n = prev_q;
`endif
        unique case (state)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    state_n = RUN;
                    phase_n = '0;
                    cur_i_n = head_i;
                    cur_q_n = head_q;
                    vld_n   = 1'b1;
                end
            end
            RUN: begin
                if (phase != LAST) begin
                    phase_n = phase + LG'(1);
                end else if (has_data) begin
                    pop     = 1'b1;
                    phase_n = '0;
`ifdef LINEAR_INTERP_EN
                    prev_i_n = cur_i;
                    prev_q_n = cur_q;
`endif
                    cur_i_n = head_i;
                    cur_q_n = head_q;
                end else begin
                    state_n = IDLE;
                    phase_n = '0;
                    vld_n   = 1'b0;
                    uf_n    = 1'b1;
                    cur_i_n = '0;
                    cur_q_n = '0;
`ifdef LINEAR_INTERP_EN
                    prev_i_n = '0;
                    prev_q_n = '0;
`endif
                end
            end
        endcase
`ifdef LINEAR_INTERP_EN
        i_n = lerp(prev_i_n, cur_i_n, phase_n);
        q_n = lerp(prev_q_n, cur_q_n, phase_n);
`else
        i_n = cur_i_n;
        q_n = cur_q_n;
`endif
        if (!vld_n) begin
            i_n = '0;
            q_n = '0;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            cur_i     <= '0;
            cur_q     <= '0;
            out_valid <= 1'b0;
            I_OUT     <= '0;
            Q_OUT     <= '0;
            underflow <= 1'b0;
        end else begin
            phase     <= phase_n;
            cur_i     <= cur_i_n;
            cur_q     <= cur_q_n;
            out_valid <= vld_n;
            I_OUT     <= i_n;
            Q_OUT     <= q_n;
            underflow <= uf_n;
        end
    end

`ifdef LINEAR_INTERP_EN
    // Last emitted sample, the start point of the next ramp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_i <= '0;
            prev_q <= '0;
        end else begin
            prev_i <= prev_i_n;
            prev_q <= prev_q_n;
        end
    end
`endif

endmodule

// File: tb/tb_tx_interp_fifo.sv
// Bench for tx_interp_fifo: queue-based reference model plus directed pins.
// Build with LINEAR_INTERP_EN to also exercise the ramp mode.
module tb_tx_interp_fifo;

    localparam int DW     = 6;
    localparam int INTERP = 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DW-1:0] I_IN = '0;
    logic signed [DW-1:0] Q_IN = '0;
    logic out_valid;
    logic signed [DW-1:0] I_OUT;
    logic signed [DW-1:0] Q_OUT;
    logic underflow;
    logic [$clog2(DEPTH):0] fifo_level;

    tx_interp_fifo #(
        .DW(DW),
        .INTERP(INTERP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .I_IN(I_IN),
        .Q_IN(Q_IN),
        .out_valid(out_valid),
        .I_OUT(I_OUT),
        .Q_OUT(Q_OUT),
        .underflow(underflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;
    int vcnt = 0;
    int ucnt = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: sample queue plus "cycles left on current sample".
    int  q_i[$];
    int  q_q[$];
    bit  m_act  = 1'b0;
    int  m_left = 0;
    int  m_ci = 0, m_cq = 0, m_pi = 0, m_pq = 0;
    bit  m_uf = 1'b0;

    function automatic int fdiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int expv(input int p, input int c, input int k);
`ifdef LINEAR_INTERP_EN
        return p + fdiv((c - p) * (k + 1), INTERP);
`else
        return c;
`endif
    endfunction

    task automatic model_reset();
        q_i.delete();
        q_q.delete();
        m_act = 0; m_left = 0; m_uf = 0;
        m_ci = 0; m_cq = 0; m_pi = 0; m_pq = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                int  sz;
                bit  acc;
                sz  = q_i.size();
                acc = in_valid && (sz < DEPTH);
                m_uf = 0;
                if (!m_act || m_left == 1) begin
                    if (sz > 0) begin
                        m_pi = m_act ? m_ci : 0;
                        m_pq = m_act ? m_cq : 0;
                        m_ci = q_i.pop_front();
                        m_cq = q_q.pop_front();
                        m_act = 1;
                        m_left = INTERP;
                    end else begin
                        if (m_act) m_uf = 1;
                        m_act = 0;
                        m_pi = 0;
                        m_pq = 0;
                    end
                end else begin
                    m_left--;
                end
                if (acc) begin
                    q_i.push_back(int'(I_IN));
                    q_q.push_back(int'(Q_IN));
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int ei, eq;
                ei = m_act ? expv(m_pi, m_ci, INTERP - m_left) : 0;
                eq = m_act ? expv(m_pq, m_cq, INTERP - m_left) : 0;
                check("m_valid", int'(out_valid), int'(m_act));
                check("m_i", int'(I_OUT), ei);
                check("m_q", int'(Q_OUT), eq);
                check("m_uf", int'(underflow), int'(m_uf));
                check("m_level", int'(fifo_level), q_i.size());
                check("m_ready", int'(in_ready), int'(q_i.size() < DEPTH));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid) vcnt++;
        if (underflow) ucnt++;
    endtask

    task automatic drive(input int i, input int q);
        in_valid = 1'b1;
        I_IN = DW'(i);
        Q_IN = DW'(q);
    endtask

    task automatic drain();
        int n = 0;
        while (!underflow && n < 60) begin
            tick();
            n++;
        end
        check("drain_uf", int'(underflow), 1);
        tick();
    endtask

    initial begin
        // Reset with in_valid asserted
        drive(9, 9);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_i", int'(I_OUT), 0);
        check("rst_q", int'(Q_OUT), 0);
        check("rst_uf", int'(underflow), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_level", int'(fifo_level), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();

        // Hold: two back-to-back samples
        drive(5, -3);
        tick();
        drive(-32, 31);
        tick();
        in_valid = 1'b0;
        check("hold_lat_v", int'(out_valid), 1);
        check("hold_s0_i", int'(I_OUT), 5);
        check("hold_s0_q", int'(Q_OUT), -3);
        repeat (3) tick();
        check("hold_s0_p3", int'(I_OUT), 5);
        tick();
        check("hold_s1_i", int'(I_OUT), -32);
        check("hold_s1_q", int'(Q_OUT), 31);
        repeat (3) tick();
        check("hold_s1_p3", int'(Q_OUT), 31);
        tick();
        check("hold_uf", int'(underflow), 1);
        check("hold_uf_v", int'(out_valid), 0);
        check("hold_uf_i", int'(I_OUT), 0);
        tick();
        check("hold_uf_1cyc", int'(underflow), 0);
        tick();

        // Backpressure: six samples, no gaps
        begin
            bit saw_full = 0;
            vcnt = 0;
            ucnt = 0;
            for (int s = 0; s < 6; s++) begin
                int n = 0;
                drive(s * 3 - 8, 10 - s * 4);
                while (!in_ready && n < 20) begin
                    saw_full = 1;
                    check("bp_full_lvl", int'(fifo_level), DEPTH);
                    tick();
                    n++;
                end
                tick();
            end
            in_valid = 1'b0;
            drain();
            check("bp_saw_full", int'(saw_full), 1);
            check("bp_vcycles", vcnt, 6 * INTERP);
            check("bp_ucnt", ucnt, 1);
        end

        // Continuous: one sample every INTERP cycles
        vcnt = 0;
        ucnt = 0;
        for (int s = 0; s < 5; s++) begin
            drive(s - 2, 2 - s);
            tick();
            in_valid = 1'b0;
            repeat (INTERP - 1) tick();
        end
        drain();
        check("cont_vcycles", vcnt, 5 * INTERP);
        check("cont_ucnt", ucnt, 1);

        // Async reset while running with level 3
        for (int s = 0; s < 4; s++) begin
            drive(s + 1, -s);
            tick();
        end
        in_valid = 1'b0;
        check("ar_pre_lvl", int'(fifo_level), 3);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", int'(out_valid), 0);
        check("ar_i", int'(I_OUT), 0);
        check("ar_level", int'(fifo_level), 0);
        check("ar_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        drive(7, 1);
        tick();
        in_valid = 1'b0;
        tick();
        check("ar_7_v", int'(out_valid), 1);
        check("ar_7_i", int'(I_OUT), 7);
        drain();

`ifdef LINEAR_INTERP_EN
        // Linear ramp
        begin
            int exp8[8] = '{2, 4, 6, 8, 6, 4, 2, 0};
            drive(8, 0);
            tick();
            drive(0, 0);
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                check("lin_ramp", int'(I_OUT), exp8[k]);
                if (k < 7) tick();
            end
            drain();
            drive(31, 0);
            tick();
            drive(-31, 0);
            tick();
            in_valid = 1'b0;
            check("lin_31_p0", int'(I_OUT), 7);
            repeat (3) tick();
            check("lin_31_p3", int'(I_OUT), 31);
            repeat (4) tick();
            check("lin_m31_p3", int'(I_OUT), -31);
            drain();
        end
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
